// File: rtl/tdm_mux2_scheduler.sv
// Two-channel word serializer feeding a 2:1 enable-gated mux.
// Each channel buffers one word; a two-state FSM shifts the chosen word out MSB first.

module tdm_mux2_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             shift_i,
    input  logic             clear_i,
    output logic             ready_o,
    output logic             msb_o,
    output logic             full_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic             full_q, full_d;
    logic             accept;

    assign accept = valid_i & ~full_q;

    always_comb begin
        sr_d   = sr_q;
        full_d = full_q;
        if (accept) begin
            sr_d   = data_i;
            full_d = 1'b1;
        end else begin
            if (shift_i) sr_d   = {sr_q[WIDTH-2:0], 1'b0};
            if (clear_i) full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            full_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            full_q <= full_d;
        end
    end

    assign ready_o = ~full_q;
    assign msb_o   = sr_q[WIDTH-1];
    assign full_o  = full_q;

endmodule

module tdm_mux2_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [1:0]       d,
    output logic             s,
    output logic             en,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    logic [1:0][WIDTH-1:0] ch_data;
    logic [1:0]            ch_valid, ch_shift, ch_clear, ch_ready, ch_msb, ch_full;

    assign ch_data  = {in1_data, in0_data};
    assign ch_valid = {in1_valid, in0_valid};
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    for (genvar g = 0; g < 2; g++) begin : g_ch
        assign ch_shift[g] = (state_q == SHIFT) && (s_q == 1'(g));
        assign ch_clear[g] = ch_shift[g] && last_bit;

        tdm_mux2_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (ch_data[g]),
            .valid_i (ch_valid[g]),
            .shift_i (ch_shift[g]),
            .clear_i (ch_clear[g]),
            .ready_o (ch_ready[g]),
            .msb_o   (ch_msb[g]),
            .full_o  (ch_full[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|ch_full) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On a tie the channel that was not served last wins.
    always_comb begin
        s_d    = s_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (|ch_full) begin
                s_d   = (&ch_full) ? ~last_q : ch_full[1];
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
                cnt_d  = '0;
                last_d = s_q;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        en        = (state_q == SHIFT);
        s         = s_q;
        done      = done_q;
        d         = ch_msb;
        in0_ready = ch_ready[0];
        in1_ready = ch_ready[1];
    end

endmodule
